// File: rtl/stall_if.sv
// Handshake bundle between the memory-access decode and the stall controller.
interface stall_if #(
    parameter int NCH = 2
);
    logic           start;
    logic [NCH-1:0] need;
    logic [NCH-1:0] ack;
    logic           hold;
    logic [NCH-1:0] done_mask;
    logic           overlap_err;
    logic           timeout;
    logic [NCH-1:0] timeout_ch;

    modport master (
        output start, need, ack,
        input  hold, done_mask, overlap_err, timeout, timeout_ch
    );

    modport slave (
        input  start, need, ack,
        output hold, done_mask, overlap_err, timeout, timeout_ch
    );
endinterface

// File: rtl/stall_ctrl.sv
// N-channel pipeline stall controller for CowCat32.
// Optional watchdog abort enabled by defining STALL_TIMEOUT_EN.
module stall_ctrl #(
    parameter int NCH      = 2,
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic    clk,
    input  logic    rst,
    stall_if.slave  bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state, state_n;
    logic [NCH-1:0] pending, pending_n;
    logic [NCH-1:0] done_q, done_n;
    logic [NCH-1:0] miss, left;
    logic           ovl_q, ovl_n;
    logic           hold;

    assign miss = bus.need & ~bus.ack;
    assign left = pending & ~bus.ack;

`ifdef STALL_TIMEOUT_EN
    localparam logic [TO_W-1:0] LAST = TO_W'(TO_LIMIT - 1);

    logic [TO_W-1:0] cnt, cnt_n;
    logic            to_q, to_n;
    logic [NCH-1:0]  toch_q, toch_n;
`endif

    always_comb begin
        state_n   = state;
        pending_n = pending;
        done_n    = done_q;
        ovl_n     = ovl_q;
        hold      = 1'b0;
`ifdef STALL_TIMEOUT_EN
        cnt_n     = cnt;
        to_n      = to_q;
        toch_n    = toch_q;
`endif
        unique case (state)
            S_IDLE: begin
                hold = bus.start & |miss;
                if (bus.start) begin
                    done_n    = bus.need & bus.ack;
                    pending_n = miss;
                    if (|miss) begin
                        state_n = S_WAIT;
`ifdef STALL_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
                end
            end
            S_WAIT: begin
                hold      = |left;
                pending_n = left;
                done_n    = done_q | (pending & bus.ack);
                if (bus.start)
                    ovl_n = 1'b1;
                if (!(|left)) begin
                    state_n = S_IDLE;
`ifdef STALL_TIMEOUT_EN
                end else if (cnt == LAST) begin
                    // abandon the step; remember who never answered
                    state_n   = S_IDLE;
                    to_n      = 1'b1;
                    toch_n    = left;
                    pending_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= '0;
            done_q  <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            done_q  <= done_n;
            ovl_q   <= ovl_n;
        end
    end

`ifdef STALL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            to_q   <= 1'b0;
            toch_q <= '0;
        end else begin
            cnt    <= cnt_n;
            to_q   <= to_n;
            toch_q <= toch_n;
        end
    end

    assign bus.timeout    = to_q;
    assign bus.timeout_ch = toch_q;
`else
    assign bus.timeout    = 1'b0;
    assign bus.timeout_ch = '0;
`endif

    assign bus.hold        = hold;
    assign bus.done_mask   = done_q;
    assign bus.overlap_err = ovl_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: step-level reference model,
// directed scenarios followed by randomized traffic.
module tb_stall_ctrl;
    localparam int NCH      = 2;
    localparam int TO_W     = 8;
    localparam int TO_LIMIT = 5;

`ifdef STALL_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    typedef struct {
        logic           hold;
        logic [NCH-1:0] done_mask;
        logic           ovl;
        logic           to;
        logic [NCH-1:0] toch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   finished = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    stall_if #(.NCH(NCH)) bus ();

    stall_ctrl #(
        .NCH(NCH), .TO_W(TO_W), .TO_LIMIT(TO_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // reference model: a step is the set of channels still owed
    bit             busy;
    logic [NCH-1:0] owed, got;
    bit             m_ovl, m_to;
    logic [NCH-1:0] m_toch;
    int             age;

    task automatic model_reset();
        busy = 0; owed = '0; got = '0;
        m_ovl = 0; m_to = 0; m_toch = '0; age = 0;
    endtask

    task automatic cyc(input bit r, input bit s,
                       input logic [NCH-1:0] n,
                       input logic [NCH-1:0] a);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; bus.start = s; bus.need = n; bus.ack = a;
        if (busy) e.hold = (owed & ~a) != 0;
        else      e.hold = s && ((n & ~a) != 0);
        e.done_mask = got; e.ovl = m_ovl;
        e.to = m_to; e.toch = m_toch;
        sb.push_back(e);
        if (r) begin
            model_reset();
        end else if (!busy) begin
            if (s) begin
                got  = n & a;
                owed = n & ~a;
                busy = owed != 0;
                age  = 0;
            end
        end else begin
            if (s) m_ovl = 1;
            got  = got | (owed & a);
            owed = owed & ~a;
            age++;
            if (owed == 0) begin
                busy = 0;
            end else if (TO_ON && age == TO_LIMIT) begin
                m_to = 1; m_toch = owed; owed = '0; busy = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("hold", 32'(bus.hold), 32'(e.hold));
            check("done_mask", 32'(bus.done_mask), 32'(e.done_mask));
            check("overlap_err", 32'(bus.overlap_err), 32'(e.ovl));
            check("timeout", 32'(bus.timeout), 32'(e.to));
            check("timeout_ch", 32'(bus.timeout_ch), 32'(e.toch));
        end
    end

    initial begin
        bus.start = 0; bus.need = '0; bus.ack = '0;
        rst = 1;
        model_reset();
        @(posedge clk);
        // reset, idle
        cyc(1, 0, 2'b00, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 0, 2'b00, 2'b00);
        // same-cycle completion
        cyc(0, 1, 2'b11, 2'b11);
        cyc(0, 0, 2'b00, 2'b00);
        // staggered acks
        cyc(0, 1, 2'b11, 2'b01);
        repeat (3) cyc(0, 0, 2'b00, 2'b00);
        cyc(0, 0, 2'b00, 2'b10);
        cyc(0, 0, 2'b00, 2'b00);
        // need=0 start
        cyc(0, 1, 2'b00, 2'b11);
        cyc(0, 0, 2'b00, 2'b00);
        // spurious ack and overlap
        cyc(0, 1, 2'b01, 2'b10);
        cyc(0, 1, 2'b11, 2'b00);
        cyc(0, 0, 2'b00, 2'b10);
        cyc(0, 0, 2'b00, 2'b01);
        cyc(0, 0, 2'b00, 2'b00);
        // watchdog: no ack after start
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 1, 2'b10, 2'b00);
        repeat (TO_ON ? 8 : 50) cyc(0, 0, 2'b00, 2'b00);
        // ack arriving on the limit cycle completes normally
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 1, 2'b01, 2'b00);
        repeat (TO_LIMIT - 1) cyc(0, 0, 2'b00, 2'b00);
        cyc(0, 0, 2'b00, 2'b01);
        cyc(0, 0, 2'b00, 2'b00);
        // reset mid-wait, then a late ack
        cyc(0, 1, 2'b01, 2'b00);
        repeat (2) cyc(0, 0, 2'b00, 2'b00);
        cyc(1, 0, 2'b00, 2'b00);
        cyc(0, 0, 2'b00, 2'b01);
        cyc(0, 0, 2'b00, 2'b00);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] n, a;
            bit r, s;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 3) == 0);
            n = NCH'($urandom);
            for (int c = 0; c < NCH; c++)
                a[c] = ($urandom_range(0, 9) < 3);
            cyc(r, s, n, a);
        end
        cyc(0, 0, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued expected 0", sb.size());
        end
        finished = 1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        if (!finished) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "bench timed out");
        end
    end
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Parametrised pipeline stall controller for the CowCat32 core that generalises the single-cycle instruction/data acknowledge check into an N-channel tracker. Each pipeline step declares which memory channels it needs. The block remembers acknowledges that arrive on different cycles and holds the pipeline until every needed channel has answered. An optional watchdog aborts a step whose memory never responds. It sits between the memory-access stage decode and the pipeline-register enables, driving the global `hold`.

## Interface
- `NCH`, 2, number of memory channels (bit 0 = instruction fetch, bits 1..NCH-1 = data ports); range 1..8
- `TO_W`, 8, width of the watchdog counter
- `TO_LIMIT`, 200, WAIT cycles before a timeout fires; must be at least 1 and at most 2^TO_W-1

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse: a new step issues its requests this cycle
- `need`  in  NCH  channels the step requires; sampled only when `start`=1
- `ack`  in  NCH  per-channel acknowledge, sampled at the rising edge; may be a pulse or a level
- `hold`  out  1  combinational; 1 = freeze the pipeline registers
- `done_mask`  out  NCH  registered; needed channels already acknowledged in the current or last step
- `overlap_err`  out  1  sticky: `start` was seen while in WAIT
- `timeout`  out  1  sticky watchdog flag (macro-dependent)
- `timeout_ch`  out  NCH  channels still pending when the timeout fired (macro-dependent)

## Operation
- State machine states: IDLE and WAIT. Internal registers: `pending[NCH]` and counter `cnt[TO_W]`.
- `hold` logic:
  - IDLE: `hold = start & |(need & ~ack)`.
  - WAIT: `hold = |(pending & ~ack)`.
  - `hold` drops combinationally in the cycle the last outstanding ack arrives, so there is zero release latency.
- Transitions from IDLE:
  - On `start`, `done_mask <= need & ack` and `pending <= need & ~ack`.
  - If `need & ~ack` is nonzero, go to WAIT and set `cnt <= 0`.
  - Otherwise stay in IDLE; no stall occurs.
- Transitions from WAIT:
  - Each cycle, `pending <= pending & ~ack` and `done_mask <= done_mask | (pending & ack)`.
  - When `pending & ~ack` is 0, go to IDLE.
- Acks on channels that are not pending (spurious, or already done) are ignored. `done_mask` never gains unneeded bits.
- A `start` received in WAIT is ignored for tracking and sets `overlap_err`. The current step continues.
- `need` = 0 with `start` produces no hold, and `done_mask` becomes 0.
- NCH=1 degenerates to fetch-only tracking.

## Timing
- Reset values (asserted on the cycle after `rst` is sampled high):
  - state IDLE, `pending` 0, `done_mask` 0, `cnt` 0, `overlap_err` 0, `timeout` 0, `timeout_ch` 0.
  - Consequently `hold` = 0 unless `start` is asserted.
- `rst` during WAIT abandons the step. `hold` is 0 in the next cycle.
- `rst` has priority over `start`, `ack`, and the timeout.
- Step latency is the number of cycles from `start` to the cycle containing the last needed ack. `hold` is high on every cycle of that span except the last.
- If all needed acks arrive together with `start`, there are 0 stall cycles.
- `done_mask` lags `ack` by one cycle because it is registered.

## Configuration
- `STALL_TIMEOUT_EN` defined:
  - `cnt` increments every WAIT cycle that does not complete the step.
  - When `cnt` reaches TO_LIMIT-1 and `pending & ~ack` is nonzero, the following happen on the next edge: go to IDLE, set `timeout` to 1, `timeout_ch <= pending & ~ack`, and `pending <= 0`.
  - `hold` is 0 from that edge onward.
  - `timeout` and `timeout_ch` are cleared only by `rst`.
  - If the last ack arrives on the limit cycle, the step completes normally and no timeout is raised.
- `STALL_TIMEOUT_EN` undefined:
  - No counter is built. WAIT persists indefinitely.
  - `timeout` and `timeout_ch` are tied to 0.

## Test plan
- Reset, idle: hold `rst` for 2 cycles, then set `start`=0. Required: `hold`=0, `done_mask`=0, all flags 0.
- Same-cycle completion (NCH=2): `start`=1, `need`=2'b11, `ack`=2'b11. Required: `hold`=0 that cycle; next cycle `done_mask`=2'b11 and state is IDLE.
- Staggered acks: `start` with `need`=2'b11 and `ack`=2'b01; 3 cycles of `ack`=0; then `ack`=2'b10. Required: `hold`=1 for 4 cycles, 0 in the ack cycle; `done_mask` reads 2'b01 then 2'b11.
- Spurious ack and overlap: `start` with `need`=2'b01, `ack`=2'b10; next cycle `start`=1 again, `ack`=0. Required: `hold` stays 1, `done_mask`=2'b00, `overlap_err`=1. A later `ack`=2'b01 releases `hold`.
- Timeout (macro on, TO_LIMIT=5): `start` with `need`=2'b10 and no ack thereafter. Required: `hold`=1 for exactly 5 cycles after `start` (6 high cycles counting the `start` cycle), then 0; `timeout`=1 and `timeout_ch`=2'b10. With the macro off, `hold` stays 1 for 50 cycles and `timeout`=0.
- Reset mid-wait: `start` with `need`=2'b01, wait 2 cycles, then assert `rst`. Required: `hold`=0 on the next cycle and `pending`/`done_mask` are 0. A later ack has no effect.
